// File: rtl/image_write.sv
// Result-stream writer: places a W x H x D segment into image memory row by row,
// starting at a base address with a configurable row pitch. Optional macro: IMAGE_WRITE_RELU_EN.
module image_write #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16,
  parameter logic [CFG_AWIDTH-1:0] CFG_IW_IMG_W  = CFG_AWIDTH'(8),
  parameter logic [CFG_AWIDTH-1:0] CFG_IW_IMG_DH = CFG_AWIDTH'(9),
  parameter logic [CFG_AWIDTH-1:0] CFG_IW_PITCH  = CFG_AWIDTH'(10),
  parameter logic [CFG_AWIDTH-1:0] CFG_IW_START  = CFG_AWIDTH'(11)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic                          next,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] result_bus,
  input  logic                          result_last,
  input  logic                          result_val,
  output logic                          result_rdy,
  output logic                          wr_val,
  output logic [MEM_AWIDTH-1:0]         wr_addr,
  output logic [GROUP_NB*IMG_WIDTH-1:0] wr_data,
  output logic                          done,
  output logic                          err_last
);

  localparam int BUS_W = GROUP_NB * IMG_WIDTH;

  typedef enum logic [3:0] {
    RESET  = 4'b0001,
    CONFIG = 4'b0010,
    LOAD   = 4'b0100,
    ACTIVE = 4'b1000
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  load_cnt;

  logic [31:0] cfg_w, cfg_dh, cfg_pitch, cfg_start;
  logic [31:0] w_q, h_q, d_q, pitch_q, start_q;
  logic [31:0] row_len, pitch, row_start, addr, col_cnt, row_cnt;

  logic accept, col_end, seg_end;

  assign accept  = result_val & result_rdy;
  assign col_end = (col_cnt == row_len - 32'd1);
  assign seg_end = col_end && (row_cnt == h_q - 32'd1);

`ifdef IMAGE_WRITE_RELU_EN
  function automatic logic [BUS_W-1:0] lane_fix(input logic [BUS_W-1:0] bus);
    logic [BUS_W-1:0] res;
    res = bus;
    for (int g = 0; g < GROUP_NB; g++) begin
      if (bus[(g+1)*IMG_WIDTH-1]) res[g*IMG_WIDTH +: IMG_WIDTH] = '0;
    end
    return res;
  endfunction
`else
  function automatic logic [BUS_W-1:0] lane_fix(input logic [BUS_W-1:0] bus);
    return bus;
  endfunction
`endif

  // NOTE: configuration registers are deliberately left out of reset so a
  // segment aborted by rst can be restarted with the previously written setup.
  always_ff @(posedge clk) begin
    if (cfg_valid) begin
      if (cfg_addr == CFG_IW_IMG_W)  cfg_w     <= cfg_data;
      if (cfg_addr == CFG_IW_IMG_DH) cfg_dh    <= cfg_data;
      if (cfg_addr == CFG_IW_PITCH)  cfg_pitch <= cfg_data;
      if (cfg_addr == CFG_IW_START)  cfg_start <= cfg_data;
    end
  end

  // NOTE: reset is synchronous, so only clk appears in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) state <= RESET;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    result_rdy = 1'b0;
    unique case (state)
      RESET:   state_nxt = CONFIG;
      CONFIG:  if (next) state_nxt = LOAD;
      LOAD:    if (load_cnt == 2'd2) state_nxt = ACTIVE;
      ACTIVE: begin
        result_rdy = 1'b1;
        if (result_val && seg_end) state_nxt = RESET;
      end
      default: state_nxt = RESET;
    endcase
  end

  // Control and write port; everything here is visible at the ports and reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt <= '0;
      wr_val   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      err_last <= 1'b0;
    end else begin
      load_cnt <= (state == LOAD) ? load_cnt + 2'd1 : 2'd0;
      wr_val   <= accept;
      done     <= accept && seg_end;
      wr_data  <= accept ? lane_fix(result_bus) : '0;
      if (accept) wr_addr <= addr[MEM_AWIDTH-1:0];
      if (state == CONFIG && next)
        err_last <= 1'b0;
      else if (accept && (result_last != seg_end))
        err_last <= 1'b1;
    end
  end

  // Segment geometry and address walk; re-initialised on every LOAD.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      unique case (load_cnt)
        2'd0: begin
          w_q     <= cfg_w + 32'd1;
          h_q     <= {16'd0, cfg_dh[15:0]} + 32'd1;
          d_q     <= {16'd0, cfg_dh[31:16]} + 32'd1;
          pitch_q <= cfg_pitch;
          start_q <= cfg_start;
        end
        2'd1: row_len <= w_q * d_q;
        default: begin
          pitch     <= (pitch_q == 32'd0) ? row_len : pitch_q;
          row_start <= start_q;
          addr      <= start_q;
          col_cnt   <= '0;
          row_cnt   <= '0;
        end
      endcase
    end else if (accept) begin
      if (col_end) begin
        // The new row begins one pitch past the current row's start, not past addr.
        col_cnt   <= '0;
        row_cnt   <= row_cnt + 32'd1;
        row_start <= row_start + pitch;
        addr      <= row_start + pitch;
      end else begin
        col_cnt <= col_cnt + 32'd1;
        addr    <= addr + 32'd1;
      end
    end
  end

endmodule

// File: doc/image_write.md
Name: image_write

Overview:
- Counterpart of the image read path: accepts the result stream produced by the layer operations and generates write requests into image memory.
- Places an output image segment of W x H x D pixels into memory in row-major order (H outer, W middle, D inner), starting at a configurable base address with a configurable row pitch, so a tile can land inside a wider buffer.
- Sits between the conv/maxpool output and the image_mem write port; loads its config on next and signals done when the segment is written.

Parameters:
- CFG_DWIDTH, 32, config data width
- CFG_AWIDTH, 5, config address width
- GROUP_NB, 4, pixel lanes per bus word
- IMG_WIDTH, 16, bits per lane (signed)
- MEM_AWIDTH, 16, memory address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cfg_data  in  CFG_DWIDTH  config data
- cfg_addr  in  CFG_AWIDTH  config register select
- cfg_valid  in  1  config write strobe
- next  in  1  load cfg and start segment
- result_bus  in  GROUP_NB*IMG_WIDTH  result pixel word
- result_last  in  1  upstream marks final word
- result_val  in  1  result word valid
- result_rdy  out  1  block accepts word
- wr_val  out  1  memory write strobe
- wr_addr  out  MEM_AWIDTH  write address
- wr_data  out  GROUP_NB*IMG_WIDTH  write data
- done  out  1  one-cycle pulse, segment complete
- err_last  out  1  sticky result_last mismatch flag

Behaviour:
- Reset: clk and rst are decided as above (rst synchronous, active-high). On reset, result_rdy, wr_val, wr_addr, wr_data, done and err_last are all 0, and state = RESET.
- Config registers use addresses from the shared cfg parameter header; written on cfg_valid with address match:
  - CFG_IW_IMG_W: [31:0] = width-1
  - CFG_IW_IMG_DH: [31:16] = depth-1, [15:0] = height-1
  - CFG_IW_PITCH: [31:0] = row pitch in addresses; 0 means contiguous (pitch = W*D)
  - CFG_IW_START: [31:0] = base address
- Config values are 0-indexed: cfg 0 means 1.
- All arithmetic is 32-bit unsigned; wr_addr is the low MEM_AWIDTH bits, and wrap-around is silent.
- State machine, one-hot RESET/CONFIG/LOAD/ACTIVE:
  - RESET -> CONFIG.
  - CONFIG: next -> LOAD. next is ignored in every other state.
  - LOAD (3 cycles): latch cfg+1 values, compute row_len = W*D (registered multiply), resolve pitch, init row_start = addr = start, init counters. Then -> ACTIVE.
  - ACTIVE: result_rdy = 1. Accept = result_val & result_rdy.
    - Each accept: col_cnt++. If col_cnt == row_len-1: col_cnt = 0, row_cnt++, row_start += pitch, addr = row_start + pitch. Otherwise addr++.
    - Accept with col_cnt == row_len-1 and row_cnt == H-1 -> RESET.
  - result_rdy is 0 in every state except ACTIVE.
- Write port:
  - Registered, latency 1: the cycle after an accept, wr_val = 1 and wr_addr/wr_data hold that word.
  - Otherwise wr_val = 0 and wr_data = 0.
  - No backpressure from memory.
- done pulses 1 cycle in the same cycle as the final wr_val.
- err_last:
  - Cleared on entering LOAD.
  - Set if result_last = 1 on an accepted non-final word, or result_last = 0 on the accepted final word.
  - Does not alter counting; the segment always ends on count.
- Gaps in result_val: counters and addr hold and no write is issued; addresses stay contiguous across gaps.
- rst mid-segment: the partial segment is abandoned with no further writes; the next segment restarts from the configured start.
- Config writes during ACTIVE affect only the next segment.

Optional Feature:
- Macro: IMAGE_WRITE_RELU_EN.
- Defined: each IMG_WIDTH lane of wr_data is ReLU'd (signed negative -> 0) in the write register stage. Latency is unchanged.
- Undefined: data is written unmodified.

Test Plan:
- cfg W=1, H=1, D=1 (each dim 2), pitch 0, start 0x10; stream 8 words, last on 8th -> wr_addr 0x10..0x17 in order, done with the 8th write, err_last = 0.
- W*D = 4 (W=1, D=1 as cfg), H=2 as cfg (3 rows), pitch 8, start 0 -> addrs 0-3, 8-11, 16-19; done after addr 19.
- Same cfg as scenario 1 with result_val toggling 1,0,0,1... -> 8 writes, addrs 0x10..0x17 with no skips, wr_val only the cycle after each accept.
- result_last on 3rd of 8 words -> err_last = 1 from the cycle after, 8 writes still issued, done on the 8th; the following next clears err_last.
- rst after 3 accepts -> next cycle wr_val = 0, result_rdy = 0; a new next re-streams from start 0x10.
- With IMAGE_WRITE_RELU_EN, lane value 0x8001 -> written 0x0000 and 0x7FFF written unchanged; without the macro, 0x8001 is written as is.
